// File: rtl/mem_responder.sv
// Single-outstanding load/store responder over an inferred word array with configurable latency.
// Define MEM_BYTE_STRB_EN to honour req_wstrb byte lanes; otherwise every valid store writes the whole word.
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        accept, enter_resp;

  logic        we_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic [3:0]  wstrb_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;

  logic [31:0] mem [DEPTH_WORDS];

  // With zero latency the RESP entry edge is the accept edge, so the live inputs are used.
  logic          from_idle;
  logic          cur_we, cur_err, mem_we;
  logic [31:0]   cur_addr, cur_wdata;
  logic [3:0]    cur_wstrb, strb_eff, lane_we;
  logic [AW-1:0] cur_idx;

  assign from_idle = (state_reg == IDLE);
  assign cur_we    = from_idle ? req_we    : we_reg;
  assign cur_addr  = from_idle ? req_addr  : addr_reg;
  assign cur_wdata = from_idle ? req_wdata : wdata_reg;
  assign cur_wstrb = from_idle ? req_wstrb : wstrb_reg;
  assign cur_idx   = cur_addr[AW+1:2];
  assign cur_err   = (cur_addr[1:0] != 2'b00) || ((cur_addr >> (AW + 2)) != 32'd0);

`ifdef MEM_BYTE_STRB_EN
  assign strb_eff = cur_wstrb;
`else
  assign strb_eff = 4'hF;
  logic unused_wstrb;
  assign unused_wstrb = ^cur_wstrb;
`endif

  // Reset suppresses the commit so a store dropped by reset never reaches the array.
  assign mem_we = rst && enter_resp && cur_we && !cur_err;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_we[gi] = mem_we & strb_eff[gi];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_reg    <= req_we;
      addr_reg  <= req_addr;
      wdata_reg <= req_wdata;
      wstrb_reg <= req_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_reg <= 32'd0;
      err_reg   <= 1'b0;
    end else if (enter_resp) begin
      err_reg   <= cur_err;
      rdata_reg <= (!cur_we && !cur_err) ? mem[cur_idx] : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (lane_we[b]) mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
    end
  end

  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a LATENCY=2 instance for most scenarios and a LATENCY=0 instance
// for back-to-back traffic; expected byte-merge results follow MEM_BYTE_STRB_EN.
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid0, req_we0, resp_ready0;
  logic [31:0] req_addr0, req_wdata0;
  logic [3:0]  req_wstrb0;
  logic        req_ready0, resp_valid0, resp_err0;
  logic [31:0] resp_rdata0;

  int checks = 0;
  int errors = 0;

  logic [32:0] sb [$];
  logic [31:0] mdl [0:1023];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_wstrb(req_wstrb0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0)
  );

  // Reference behaviour of one transaction: returns {err, rdata} and updates the shadow array.
  function automatic logic [32:0] model_apply(input logic we, input logic [31:0] addr,
                                              input logic [31:0] wdata, input logic [3:0] strb);
    logic [9:0] idx;
    if (addr[1:0] != 2'b00 || addr >= 32'd4096) return {1'b1, 32'd0};
    idx = addr[11:2];
    if (we) begin
`ifdef MEM_BYTE_STRB_EN
      for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][8*b +: 8] = wdata[8*b +: 8];
`else
      mdl[idx] = wdata;
`endif
      return {1'b0, 32'd0};
    end
    return {1'b0, mdl[idx]};
  endfunction

  task automatic transact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input string tag, output logic [31:0] rdata);
    int n;
    logic [32:0] exp_v, got_v;
    sb.push_back(model_apply(we, addr, wdata, strb));
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready got %b exp 1", tag, req_ready);
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_wstrb = 4'($urandom);
    n = 1;
    while (resp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != LAT + 1) begin
      errors++; $display("FAIL %s latency got %0d exp %0d", tag, n, LAT + 1);
    end
    got_v = {resp_err, resp_rdata};
    exp_v = sb.pop_front();
    rdata = resp_rdata;
    checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL %s resp got err=%b rdata=%h exp err=%b rdata=%h",
                         tag, got_v[32], got_v[31:0], exp_v[32], exp_v[31:0]);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL %s retire resp_valid got %b exp 0", tag, resp_valid);
    end
    $display("txn %s we=%b addr=%h wdata=%h strb=%h -> err=%b rdata=%h lat=%0d",
             tag, we, addr, wdata, strb, got_v[32], got_v[31:0], n);
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    resp_ready = 1'b0;
    req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_wstrb0 = '0;
    resp_ready0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_err, resp_rdata} !== 34'd0) begin
      errors++; $display("FAIL reset_outputs got valid=%b err=%b rdata=%h exp all 0",
                         resp_valid, resp_err, resp_rdata);
    end
    checks++;
    if ({resp_valid0, resp_err0, resp_rdata0} !== 34'd0) begin
      errors++; $display("FAIL reset_outputs0 got valid=%b err=%b rdata=%h exp all 0",
                         resp_valid0, resp_err0, resp_rdata0);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || req_ready0 !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b/%b exp 1/1", req_ready, req_ready0);
    end
    $display("txn reset done");
  endtask

  task automatic test_basic();
    logic [31:0] r;
    transact(1'b1, 32'h0, 32'h0000_0000, 4'hF, "init0", r);
    transact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "store10", r);
    transact(1'b0, 32'h10, 32'h0, 4'h0, "load10", r);
    checks++;
    if (r !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_const got %h exp deadbeef", r);
    end
    transact(1'b1, 32'hFFC, 32'h5A5A_A5A5, 4'hF, "store_top", r);
    transact(1'b0, 32'hFFC, 32'h0, 4'h0, "load_top", r);
  endtask

  task automatic test_byte_strobe();
    logic [31:0] r, want;
    transact(1'b1, 32'h10, 32'h11223344, 4'h5, "strb5", r);
    transact(1'b0, 32'h10, 32'h0, 4'h0, "load_strb", r);
`ifdef MEM_BYTE_STRB_EN
    want = 32'hDE22BE44;
`else
    want = 32'h11223344;
`endif
    checks++;
    if (r !== want) begin
      errors++; $display("FAIL strb_const got %h exp %h", r, want);
    end
    transact(1'b1, 32'h30, 32'h76543210, 4'hF, "store30", r);
    transact(1'b1, 32'h30, 32'h89ABCDEF, 4'h0, "strb0", r);
    transact(1'b0, 32'h30, 32'h0, 4'h0, "load30", r);
  endtask

  task automatic test_errors();
    logic [31:0] r;
    transact(1'b1, 32'h13, 32'hFFFF_FFFF, 4'hF, "mis_store", r);
    transact(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, "oor_store", r);
    transact(1'b1, 32'hFFFF_F010, 32'hFFFF_FFFF, 4'hF, "nowrap_store", r);
    transact(1'b0, 32'h10, 32'h0, 4'h0, "load10_after", r);
    transact(1'b0, 32'h0, 32'h0, 4'h0, "load0_after", r);
    transact(1'b0, 32'h12, 32'h0, 4'h0, "mis_load", r);
    transact(1'b0, 32'h1004, 32'h0, 4'h0, "oor_load", r);
  endtask

  task automatic test_backpressure();
    logic [32:0] exp_v;
    logic [31:0] held, r;
    int n;
    sb.push_back(model_apply(1'b0, 32'h10, 32'h0, 4'h0));
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (resp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != LAT + 1) begin
      errors++; $display("FAIL bp_latency got %0d exp %0d", n, LAT + 1);
    end
    exp_v = sb.pop_front();
    held = resp_rdata;
    checks++;
    if ({resp_err, resp_rdata} !== exp_v) begin
      errors++; $display("FAIL bp_resp got %h exp %h", {resp_err, resp_rdata}, exp_v);
    end
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hBAD0BAD0; req_wstrb = 4'hF;
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp_v[31:0] || req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got valid=%b rdata=%h ready=%b exp 1 %h 0",
                           i, resp_valid, resp_rdata, req_ready, exp_v[31:0]);
      end
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_retire got valid=%b ready=%b exp 0 1", resp_valid, req_ready);
    end
    $display("txn backpressure held=%h", held);
    transact(1'b0, 32'h10, 32'h0, 4'h0, "load10_bp", r);
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] r;
    transact(1'b1, 32'h20, 32'h0BADF00D, 4'hF, "store20", r);
    transact(1'b0, 32'h20, 32'h0, 4'h0, "load20", r);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL rw_inwait got valid=%b ready=%b exp 0 0", resp_valid, req_ready);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_err, resp_rdata} !== 34'd0) begin
      errors++; $display("FAIL rw_outputs got valid=%b err=%b rdata=%h exp all 0",
                         resp_valid, resp_err, resp_rdata);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL rw_release got ready=%b valid=%b exp 1 0", req_ready, resp_valid);
    end
    $display("txn reset_in_wait done");
    transact(1'b0, 32'h20, 32'h0, 4'h0, "load20_after", r);
    checks++;
    if (r !== 32'h0BADF00D) begin
      errors++; $display("FAIL rw_const got %h exp 0badf00d", r);
    end
  endtask

  task automatic test_back_to_back();
    logic        we_t   [3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] addr_t [3] = '{32'h40, 32'h40, 32'h40};
    logic [32:0] exp_v;
    sb.push_back({1'b0, 32'd0});
    sb.push_back({1'b0, 32'h12345678});
    sb.push_back({1'b0, 32'h12345678});
    resp_ready0 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      req_valid0 = 1'b1; req_we0 = we_t[i]; req_addr0 = addr_t[i];
      req_wdata0 = 32'h12345678; req_wstrb0 = 4'hF;
      @(posedge clk);
      @(negedge clk);
      req_valid0 = 1'b0; req_wdata0 = $urandom;
      exp_v = sb.pop_front();
      checks++;
      if (resp_valid0 !== 1'b1 || req_ready0 !== 1'b0) begin
        errors++; $display("FAIL b2b%0d_valid got valid=%b ready=%b exp 1 0", i, resp_valid0, req_ready0);
      end
      checks++;
      if ({resp_err0, resp_rdata0} !== exp_v) begin
        errors++; $display("FAIL b2b%0d_resp got %h exp %h", i, {resp_err0, resp_rdata0}, exp_v);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (req_ready0 !== 1'b1 || resp_valid0 !== 1'b0) begin
        errors++; $display("FAIL b2b%0d_retire got ready=%b valid=%b exp 1 0", i, req_ready0, resp_valid0);
      end
      $display("txn b2b%0d we=%b addr=%h -> err=%b rdata=%h", i, we_t[i], addr_t[i], resp_err0, resp_rdata0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_strobe();
    test_errors();
    test_backpressure();
    test_reset_in_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
